// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit boundary: imem request/response, redirect input and decode handoff.
// Both handshakes transfer on a rising edge where valid && ready; valid and its payload
// are held until that edge. The imem response has no ready and must always be taken.
interface if_fetch_unit_if;
    import mips_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; push while full is allowed when a pop
// happens in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Owns the PC, issues in-order imem fetches under a credit limit, buffers responses and
// hands {instr, pc, pc+4} to decode; redirects flush the buffer and drain stale responses.
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
    parameter int              DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_fetch_unit_if.master       bus,
    output fetch_state_e          fsm_state
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_target;
    logic            accept;
    logic            rsp_pop;
    logic            credit;
    logic [CW:0]     occupancy;
    logic [CW:0]     inflight_after;

    logic [XLEN-1:0] rsp_addr;
    logic [CW-1:0]   inflight;
    logic            addr_full;
    logic            addr_empty;

    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic [CW-1:0]   entry_count;
    logic            entry_full;
    logic            entry_empty;
    logic            entry_push;

    assign redirect_target = bus.redirect_pc & ~(XLEN'(3));
    assign occupancy       = {1'b0, entry_count} + {1'b0, inflight};
    assign credit          = !addr_full && !entry_full && (occupancy < (CW+1)'(DEPTH));

    // rst_n gates the request so nothing is offered while the bus is held in reset.
    assign bus.imem_req_valid = rst_n && (state == FETCH) && !bus.redirect_valid && credit;
    assign bus.imem_req_addr  = pc;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp_pop        = bus.imem_rsp_valid && !addr_empty;
    assign entry_push     = rsp_pop && (state == FETCH) && !bus.redirect_valid;
    assign inflight_after = {1'b0, inflight} + {{CW{1'b0}}, accept} - {{CW{1'b0}}, rsp_pop};

    assign push_entry = '{instr: bus.imem_rsp_data, pc: rsp_addr, pc_plus4: rsp_addr + PC_STEP};

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (accept),
        .wdata (pc),
        .pop   (rsp_pop),
        .rdata (rsp_addr),
        .count (inflight),
        .full  (addr_full),
        .empty (addr_empty)
    );

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_entry_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (entry_push),
        .wdata (push_entry),
        .pop   (bus.id_valid && bus.id_ready),
        .rdata (head),
        .count (entry_count),
        .full  (entry_full),
        .empty (entry_empty)
    );

    // Empty buffer presents the reset-time values rather than stale storage.
    assign bus.id_valid    = !entry_empty;
    assign bus.id_instr    = entry_empty ? '0 : head.instr;
    assign bus.id_pc       = entry_empty ? '0 : head.pc;
    assign bus.id_pc_plus4 = entry_empty ? PC_STEP : head.pc_plus4;
    assign fsm_state       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= FETCH;
        end else begin
            if (bus.redirect_valid) pc <= redirect_target;
            else if (accept)        pc <= pc + PC_STEP;
            unique case (state)
                FETCH: if (bus.redirect_valid && inflight_after != '0) state <= DRAIN;
                DRAIN: if (inflight_after == '0) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> !addr_empty);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, streaming, backpressure, redirects, PC wrap.
module tb_if_fetch_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_unit_if bus ();
    if_fetch_unit_if bw ();
    fetch_state_e st;
    fetch_state_e st_w;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (st)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bw),
        .fsm_state (st_w)
    );

    int          n_vec = 0;
    int          n_miss = 0;
    int          n_acc;
    logic [31:0] exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] exp_addr;
    logic        mem_hold;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic set_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        bw.imem_req_ready  = 1'b0;
        bw.imem_rsp_valid  = 1'b0;
        bw.imem_rsp_data   = '0;
        bw.redirect_valid  = 1'b0;
        bw.redirect_pc     = '0;
        bw.id_ready        = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        mem_hold = 1'b0;
        pend_q.delete();
        exp_q.delete();
        n_acc = 0;
        exp_addr = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: memory answers the oldest accepted fetch, then accepts and decode pops
    // are sampled just before the edge. Starts and ends on a falling edge.
    task automatic cycle();
        logic [31:0] a;
        logic [31:0] e;
        if (!mem_hold && pend_q.size() > 0) begin
            a = pend_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(a);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check_vec("req_addr", bus.imem_req_addr, exp_addr);
            pend_q.push_back(bus.imem_req_addr);
            exp_addr += 32'd4;
            n_acc++;
        end
        if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEE0;
            check_vec("id_pc", bus.id_pc, e);
            check_vec("id_instr", bus.id_instr, instr_of(e));
            check_vec("id_pc_plus4", bus.id_pc_plus4, e + 32'd4);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_empty(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
        check_vec("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held, then first request after release.
        rst_n = 1'b0;
        set_idle();
        mem_hold = 1'b0;
        exp_addr = 32'h0;
        n_acc = 0;
        repeat (2) @(negedge clk);
        #1;
        check_vec("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_vec("rst_id_valid", 32'(bus.id_valid), 32'd0);
        check_vec("rst_id_instr", bus.id_instr, 32'h0);
        check_vec("rst_id_pc", bus.id_pc, 32'h0);
        check_vec("rst_id_pc_plus4", bus.id_pc_plus4, 32'h4);
        check_vec("rst_state", 32'(st), 32'(FETCH));
        rst_n = 1'b1;
        #1;
        check_vec("rel_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_vec("rel_req_addr", bus.imem_req_addr, 32'h0);
        check_vec("rel_w_req_addr", bw.imem_req_addr, 32'hFFFF_FFFC);
        @(negedge clk);

        // Streaming with a 1-cycle memory.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        run_until_empty(40);

        // Decode backpressure: only DEPTH fetches go out, then resume without loss.
        do_reset();
        bus.imem_req_ready = 1'b1;
        repeat (8) cycle();
        check_vec("bp_accepts", 32'(n_acc), 32'd2);
        #1;
        check_vec("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_vec("bp_id_valid", 32'(bus.id_valid), 32'd1);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        run_until_empty(40);

        // Redirect while streaming flushes buffered entries.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        exp_addr = 32'h40;
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        check_vec("flush_id_valid", 32'(bus.id_valid), 32'd0);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        run_until_empty(40);

        // Redirect with two fetches in flight; unaligned target is word-aligned.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.id_ready = 1'b1;
        mem_hold = 1'b1;
        cycle();
        cycle();
        check_vec("rd_accepts", 32'(n_acc), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0102;
        exp_addr = 32'h100;
        cycle();
        bus.redirect_valid = 1'b0;
        mem_hold = 1'b0;
        #1;
        check_vec("rd_state_drain", 32'(st), 32'(DRAIN));
        check_vec("rd_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_vec("rd_id_valid", 32'(bus.id_valid), 32'd0);
        cycle();
        check_vec("rd_state_drain2", 32'(st), 32'(DRAIN));
        check_vec("rd_id_valid2", 32'(bus.id_valid), 32'd0);
        cycle();
        #1;
        check_vec("rd_state_fetch", 32'(st), 32'(FETCH));
        check_vec("rd_req_addr", bus.imem_req_addr, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        run_until_empty(40);

        // Redirect coincident with a response, then a second redirect during DRAIN.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.id_ready = 1'b1;
        mem_hold = 1'b1;
        cycle();
        cycle();
        mem_hold = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0300;
        exp_addr = 32'h300;
        #1;
        check_vec("co_req_valid", 32'(bus.imem_req_valid), 32'd0);
        cycle();
        mem_hold = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        exp_addr = 32'h200;
        cycle();
        bus.redirect_valid = 1'b0;
        mem_hold = 1'b0;
        #1;
        check_vec("co_state_drain", 32'(st), 32'(DRAIN));
        cycle();
        #1;
        check_vec("co_state_fetch", 32'(st), 32'(FETCH));
        check_vec("co_req_addr", bus.imem_req_addr, 32'h200);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        run_until_empty(40);

        // Asynchronous reset in the middle of a stream.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
        repeat (6) cycle();
        check_vec("mid_sb", 32'(exp_q.size()), 32'd0);
        bus.id_ready = 1'b0;
        #1;
        check_vec("mid_pre_id_valid", 32'(bus.id_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_vec("mid_id_valid", 32'(bus.id_valid), 32'd0);
        check_vec("mid_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_vec("mid_id_pc_plus4", bus.id_pc_plus4, 32'h4);
        check_vec("mid_id_pc", bus.id_pc, 32'h0);
        check_vec("mid_state", 32'(st), 32'(FETCH));

        // PC wrap on the instance reset to 0xFFFF_FFFC; address held while not accepted.
        do_reset();
        @(negedge clk);
        #1;
        check_vec("w_req_valid", 32'(bw.imem_req_valid), 32'd1);
        check_vec("w_hold_addr", bw.imem_req_addr, 32'hFFFF_FFFC);
        bw.imem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        check_vec("w_second_addr", bw.imem_req_addr, 32'h0);
        bw.imem_rsp_valid = 1'b1;
        bw.imem_rsp_data = 32'h1234_5678;
        @(negedge clk);
        bw.imem_rsp_valid = 1'b0;
        bw.imem_req_ready = 1'b0;
        #1;
        check_vec("w_id_valid", 32'(bw.id_valid), 32'd1);
        check_vec("w_id_pc", bw.id_pc, 32'hFFFF_FFFC);
        check_vec("w_id_pc_plus4", bw.id_pc_plus4, 32'h0);
        check_vec("w_id_instr", bw.id_instr, 32'h1234_5678);
        check_vec("w_req_addr", bw.imem_req_addr, 32'h4);
        check_vec("w_credit_stop", 32'(bw.imem_req_valid), 32'd0);
        check_vec("w_state", 32'(st_w), 32'(FETCH));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
